hazard_ctrl: RTL
================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameters: REG_ADDR_WIDTH, default 5, register index width; CNT_WIDTH, default 16, performance counter width; WAIT_LIMIT, default 255, memory-wait cycles before timeout.
REQ-002 SHALL have one clock and a synchronous, active-low reset: clk  in  1  clock, all state updates on rising edge; rst_n  in  1  synchronous active-low reset.
REQ-003 SHALL have these ports: Rs1D, Rs2D  in  REG_ADDR_WIDTH  decode-stage source registers.
REQ-004 SHALL have these ports: Rs1E, Rs2E  in  REG_ADDR_WIDTH  execute-stage source registers.
REQ-005 SHALL have these ports: RdE, RdM, RdW  in  REG_ADDR_WIDTH  destination registers in E, M and W.
REQ-006 SHALL have these ports: RegWriteM, RegWriteW  in  1  destination write enables in M and W.
REQ-007 SHALL have this port: LoadE  in  1  instruction in E is a load.
REQ-008 SHALL have this port: PCSrcE  in  1  taken branch or jump resolved in E.
REQ-009 SHALL have these ports: MemReqM  in  1  M-stage memory access active; MemReadyM  in  1  memory access completes this cycle.
REQ-010 SHALL have these ports: ForwardAE, ForwardBE  out  2  forwarding select, 00 register file, 01 ResultW, 10 ALUResultM.
REQ-011 SHALL have these ports: StallF, StallD, StallE, StallM, StallW  out  1  hold the stage register.
REQ-012 SHALL have these ports: FlushD, FlushE  out  1  bubble the stage register.
REQ-013 SHALL have these ports: MemTimeout  out  1  sticky wait-timeout flag; StallCycles, FlushCount  out  CNT_WIDTH  performance counters.

Function
REQ-014 ForwardAE SHALL be 10 if RegWriteM && RdM!=0 && RdM==Rs1E; otherwise 01 if RegWriteW && RdW!=0 && RdW==Rs1E; otherwise 00. ForwardBE SHALL use the same rule with Rs2E.
REQ-015 The M-stage match SHALL take priority over the W-stage match, and register x0 SHALL never be forwarded.
REQ-016 A load-use hazard is LoadE && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
REQ-017 On a load-use hazard in RUN, with no branch and no memory stall: StallF=1, StallD=1, FlushE=1, and all other stalls and flushes 0.
REQ-018 PCSrcE=1 in RUN SHALL assert FlushD=1 and FlushE=1.
REQ-019 Branch SHALL win over load-use in the same cycle: StallF=0 and StallD=0, because the instruction in D is on the wrong path.
REQ-020 The FSM SHALL have two states, RUN and WAIT.
REQ-021 RUN SHALL go to WAIT at the edge when MemReqM && !MemReadyM.
REQ-022 WAIT SHALL go to RUN at the edge when MemReadyM=1.
REQ-023 A memory stall is (RUN && MemReqM && !MemReadyM) || (WAIT && !MemReadyM); it is combinational and covers the first miss cycle.
REQ-024 During a memory stall: StallF, StallD, StallE, StallM and StallW SHALL all be 1, FlushD=0 and FlushE=0, and load-use and branch effects are suppressed.
REQ-025 Forwarding selects SHALL still follow REQ-014 during a memory stall; values remain stable because W is held.
REQ-026 In the cycle where WAIT sees MemReadyM=1, all stalls SHALL be 0 and the load-use and branch rules SHALL apply normally.
REQ-027 The wait counter (8-bit minimum) SHALL clear on RUN->WAIT and increment each WAIT cycle.
REQ-028 When the wait counter reaches WAIT_LIMIT, MemTimeout SHALL set and remain 1 until reset; the FSM stays in WAIT and the counter saturates.
REQ-029 StallCycles SHALL increment on each cycle StallF=1, saturating at all-ones.
REQ-030 FlushCount SHALL increment on each cycle PCSrcE causes a flush (REQ-018 applied), saturating at all-ones.
REQ-031 No input combination SHALL produce StallE=1 together with FlushE=1.

Reset
REQ-032 When rst_n=0 at an edge: state=RUN, wait counter=0, MemTimeout=0, StallCycles=0, FlushCount=0.
REQ-033 While rst_n=0, all stall and flush outputs SHALL be 0, overriding combinational terms.
REQ-034 Reset asserted in WAIT SHALL return the FSM to RUN at the next edge regardless of MemReadyM.

Verification
REQ-035 Forward: RdM=RdW=5, RegWriteM=RegWriteW=1, Rs1E=5 -> ForwardAE=10; same with RdM=RdW=0 -> ForwardAE=00.
REQ-036 Load-use: LoadE=1, RdE=3, Rs2D=3 -> StallF=1, StallD=1, FlushE=1 for one cycle; StallCycles goes 0->1.
REQ-037 Branch and load-use together: PCSrcE=1 with REQ-036 inputs -> FlushD=1, FlushE=1, StallF=0, StallD=0; FlushCount goes 0->1.
REQ-038 Miss: MemReqM=1, MemReadyM=0 for 4 cycles, then 1 -> all stalls 1 for 4 cycles and 0 on the ready cycle; state returns to RUN.
REQ-039 Timeout: MemReadyM held 0 for 300 cycles -> MemTimeout=1 after 255 WAIT cycles and stays 1; reset clears it and returns the FSM to RUN.
REQ-040 Counters: force StallF high for 70000 cycles -> StallCycles=0xFFFF, with no wrap.

Source files
------------

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard unit: forwarding, load-use/branch/memory stalls, perf counters
module hazard_ctrl #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 16,
  parameter int WAIT_LIMIT     = 255
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1E,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2E,
  input  logic [REG_ADDR_WIDTH-1:0] RdE,
  input  logic [REG_ADDR_WIDTH-1:0] RdM,
  input  logic [REG_ADDR_WIDTH-1:0] RdW,
  input  logic                      RegWriteM,
  input  logic                      RegWriteW,
  input  logic                      LoadE,
  input  logic                      PCSrcE,
  input  logic                      MemReqM,
  input  logic                      MemReadyM,
  output logic [1:0]                ForwardAE,
  output logic [1:0]                ForwardBE,
  output logic                      StallF,
  output logic                      StallD,
  output logic                      StallE,
  output logic                      StallM,
  output logic                      StallW,
  output logic                      FlushD,
  output logic                      FlushE,
  output logic                      MemTimeout,
  output logic [CNT_WIDTH-1:0]      StallCycles,
  output logic [CNT_WIDTH-1:0]      FlushCount
);

  localparam int WCW = ($clog2(WAIT_LIMIT + 1) > 8) ? $clog2(WAIT_LIMIT + 1) : 8;
  localparam logic [WCW-1:0] WLIM = WCW'(WAIT_LIMIT);

  typedef enum logic {S_RUN, S_WAIT} state_t;

  state_t         state;
  logic [WCW-1:0] wait_cnt;
  logic           load_use;
  logic           mem_stall;
  logic           branch_flush;

  // M-stage result is younger than W, so it wins; x0 is hardwired and never forwarded
  always_comb begin
    ForwardAE = 2'b00;
    if (RegWriteM && RdM != '0 && RdM == Rs1E)      ForwardAE = 2'b10;
    else if (RegWriteW && RdW != '0 && RdW == Rs1E) ForwardAE = 2'b01;
    ForwardBE = 2'b00;
    if (RegWriteM && RdM != '0 && RdM == Rs2E)      ForwardBE = 2'b10;
    else if (RegWriteW && RdW != '0 && RdW == Rs2E) ForwardBE = 2'b01;
  end

  assign load_use  = LoadE && RdE != '0 && (RdE == Rs1D || RdE == Rs2D);
  assign mem_stall = (state == S_RUN  && MemReqM && !MemReadyM) ||
                     (state == S_WAIT && !MemReadyM);

  // Priority: reset, memory stall (freezes everything), branch (D is wrong path), load-use
  always_comb begin
    StallF       = 1'b0;
    StallD       = 1'b0;
    StallE       = 1'b0;
    StallM       = 1'b0;
    StallW       = 1'b0;
    FlushD       = 1'b0;
    FlushE       = 1'b0;
    branch_flush = 1'b0;
    if (rst_n) begin
      if (mem_stall) begin
        StallF = 1'b1;
        StallD = 1'b1;
        StallE = 1'b1;
        StallM = 1'b1;
        StallW = 1'b1;
      end else if (PCSrcE) begin
        FlushD       = 1'b1;
        FlushE       = 1'b1;
        branch_flush = 1'b1;
      end else if (load_use) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_RUN;
      wait_cnt    <= '0;
      MemTimeout  <= 1'b0;
      StallCycles <= '0;
      FlushCount  <= '0;
    end else begin
      case (state)
        S_RUN: begin
          if (MemReqM && !MemReadyM) begin
            state    <= S_WAIT;
            wait_cnt <= '0;
          end
        end
        S_WAIT: begin
          if (MemReadyM) state <= S_RUN;
          if (wait_cnt != WLIM) wait_cnt <= wait_cnt + 1'b1;
          // sets on the edge where the counter lands on the limit, then sticks
          if (wait_cnt >= WLIM - 1'b1) MemTimeout <= 1'b1;
        end
        default: state <= S_RUN;
      endcase
      if (StallF && StallCycles != '1)      StallCycles <= StallCycles + 1'b1;
      if (branch_flush && FlushCount != '1) FlushCount  <= FlushCount + 1'b1;
    end
  end

endmodule
